// File: rtl/apb_fb_fill_master_if.sv
// apb_fb_fill_master_if: command handshake plus APB write bus between a fill master and its peers
interface apb_fb_fill_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [9:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;
  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, out_pready, out_prdata, out_pslverr,
    output cmd_ready, busy, done, err, out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
           out_pwdata, out_pstrb
  );
  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, out_pready, out_prdata, out_pslverr,
    input  cmd_ready, busy, done, err, out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
           out_pwdata, out_pstrb
  );
endinterface

// File: rtl/apb_fb_fill_master.sv
// apb_fb_fill_master: fills a clipped frame-buffer rectangle with one colour, one APB write per pixel
module apb_fb_fill_master #(
  parameter logic [31:0] FB_BASE = 32'h2100_0000,
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480
) (
  input logic clock,
  input logic reset,
  apb_fb_fill_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FIN} state_t;
  localparam logic [10:0] HR    = 11'(H_RES);
  localparam logic [10:0] VR    = 11'(V_RES);
  localparam logic [31:0] PITCH = 32'(H_RES * 4);
  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, col_q, col_d, row_q, row_d;
  logic [10:0] last_col_q, last_col_d, last_row_q, last_row_d;
  logic [31:0] row_base_q, row_base_d, paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic        psel_q, psel_d, penable_q, penable_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, cmd_ready_q, cmd_ready_d;
  logic [10:0] w11, h11, room_x, room_y, ew, eh;
  logic [31:0] start;
  logic        degen, last_px, row_end;
  logic        unused;
  assign unused = ^bus.out_prdata;
  assign w11    = {1'b0, bus.cmd_w};
  assign h11    = {1'b0, bus.cmd_h};
  assign room_x = HR - {1'b0, bus.cmd_x};
  assign room_y = VR - {1'b0, bus.cmd_y};
  assign ew     = (w11 < room_x) ? w11 : room_x;
  assign eh     = (h11 < room_y) ? h11 : room_y;
  assign degen  = ({1'b0, bus.cmd_x} >= HR) || ({1'b0, bus.cmd_y} >= VR) || ew == 11'd0 || eh == 11'd0;
  // The only multiply happens once per command; per-pixel addressing is add-only.
  assign start  = FB_BASE + (({22'b0, bus.cmd_y} * 32'(H_RES) + {22'b0, bus.cmd_x}) << 2);
  assign row_end = {1'b0, col_q} == last_col_q;
  assign last_px = row_end && {1'b0, row_q} == last_row_q;
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    col_d       = col_q;
    row_d       = row_q;
    last_col_d  = last_col_q;
    last_row_d  = last_row_q;
    row_base_d  = row_base_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cmd_ready_d = cmd_ready_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        x_d         = bus.cmd_x;
        col_d       = bus.cmd_x;
        row_d       = bus.cmd_y;
        last_col_d  = {1'b0, bus.cmd_x} + ew - 11'd1;
        last_row_d  = {1'b0, bus.cmd_y} + eh - 11'd1;
        row_base_d  = start;
        paddr_d     = start;
        pwdata_d    = {8'h00, bus.cmd_color};
        err_d       = 1'b0;
        busy_d      = 1'b1;
        cmd_ready_d = 1'b0;
        state_d     = degen ? FIN : SETUP;
        psel_d      = !degen;
        done_d      = degen;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (bus.out_pready) begin
        penable_d = 1'b0;
        if (bus.out_pslverr || last_px) begin
          state_d = FIN;
          psel_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = bus.out_pslverr;
        end else begin
          state_d    = SETUP;
          col_d      = row_end ? x_q : col_q + 10'd1;
          row_d      = row_end ? row_q + 10'd1 : row_q;
          row_base_d = row_end ? row_base_q + PITCH : row_base_q;
          paddr_d    = row_end ? row_base_q + PITCH : paddr_q + 32'd4;
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      last_col_q  <= '0;
      last_row_q  <= '0;
      row_base_q  <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_col_q  <= last_col_d;
      last_row_q  <= last_row_d;
      row_base_q  <= row_base_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.out_paddr   = paddr_q;
  assign bus.out_psel    = psel_q;
  assign bus.out_penable = penable_q;
  assign bus.out_pprot   = 3'b000;
  assign bus.out_pwrite  = 1'b1;
  assign bus.out_pwdata  = pwdata_q;
  assign bus.out_pstrb   = 4'hF;
endmodule
